// File: rtl/btn_counter.sv
// Push-button up/down counter with load: two debounced buttons and a load switch
// maintain an N-bit count bounded by MAX, with wrap or saturate at the limits.

module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_s,
    output logic o_pulse
);
    // state        | meaning
    // RELEASED     | button idle, waiting for a low level
    // PRESS_WAIT   | low seen, counting stable-low cycles
    // PRESSED      | press accepted, waiting for a high level
    // RELEASE_WAIT | high seen, counting stable-high cycles
    localparam int CW = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RELEASED: if (!i_s) begin
                w_state_nxt = PRESS_WAIT;
                w_cnt_nxt   = '0;
            end
            PRESS_WAIT: begin
                if (i_s)                    w_state_nxt = RELEASED;
                else if (r_cnt == CNT_LAST) w_state_nxt = PRESSED;
                else                        w_cnt_nxt   = r_cnt + CW'(1);
            end
            PRESSED: if (i_s) begin
                w_state_nxt = RELEASE_WAIT;
                w_cnt_nxt   = '0;
            end
            RELEASE_WAIT: begin
                if (!i_s)                   w_state_nxt = PRESSED;
                else if (r_cnt == CNT_LAST) w_state_nxt = RELEASED;
                else                        w_cnt_nxt   = r_cnt + CW'(1);
            end
            default: w_state_nxt = RELEASED;
        endcase
    end

    // Pulse coincides with the PRESS_WAIT -> PRESSED transition edge.
    always_comb begin
        o_pulse = (r_state == PRESS_WAIT) && !i_s && (r_cnt == CNT_LAST);
    end
endmodule

module btn_counter #(
    parameter int N          = 6,
    parameter int MAX        = 63,
    parameter int DEB_CYCLES = 500000,
    parameter int WRAP       = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         btn_up_n,
    input  logic         btn_dn_n,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] number,
    output logic         wrap_pulse
);
    localparam logic [N-1:0] MAX_V = N'(MAX);

    logic         r_up_meta, r_up_s, r_dn_meta, r_dn_s;
    logic         r_ld_meta, r_ld_s, r_ld_prev;
    logic [N-1:0] r_number;
    logic         r_wrap;
    logic         w_up_pulse, w_dn_pulse, w_load_rise;
    logic [N-1:0] w_load_sat;

    // Buttons idle high, so their synchronisers reset to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_up_meta <= 1'b1;
            r_up_s    <= 1'b1;
            r_dn_meta <= 1'b1;
            r_dn_s    <= 1'b1;
            r_ld_meta <= 1'b0;
            r_ld_s    <= 1'b0;
            r_ld_prev <= 1'b0;
        end else begin
            r_up_meta <= btn_up_n;
            r_up_s    <= r_up_meta;
            r_dn_meta <= btn_dn_n;
            r_dn_s    <= r_dn_meta;
            r_ld_meta <= load;
            r_ld_s    <= r_ld_meta;
            r_ld_prev <= r_ld_s;
        end
    end

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk(clk), .rst_n(rst_n), .i_s(r_up_s), .o_pulse(w_up_pulse)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
        .clk(clk), .rst_n(rst_n), .i_s(r_dn_s), .o_pulse(w_dn_pulse)
    );

    assign w_load_rise = r_ld_s & ~r_ld_prev;
    assign w_load_sat  = (load_val > MAX_V) ? MAX_V : load_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_number <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_load_rise) begin
                r_number <= w_load_sat;
            end else if (w_up_pulse && w_dn_pulse) begin
                r_number <= r_number;
            end else if (w_up_pulse) begin
                if (r_number >= MAX_V) begin
                    if (WRAP != 0) begin
                        r_number <= '0;
                        r_wrap   <= 1'b1;
                    end
                end else begin
                    r_number <= r_number + N'(1);
                end
            end else if (w_dn_pulse) begin
                if (r_number == '0) begin
                    if (WRAP != 0) begin
                        r_number <= MAX_V;
                        r_wrap   <= 1'b1;
                    end
                end else begin
                    r_number <= r_number - N'(1);
                end
            end
        end
    end

    assign number     = r_number;
    assign wrap_pulse = r_wrap;
endmodule

// File: tb/tb_btn_counter.sv
// Bench for btn_counter: three instances (wrap/63, saturate/63, wrap/59) share stimulus
// and are checked against hand-derived expectations.

module tb_btn_counter;
    localparam int N   = 6;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         btn_up_n = 1'b1;
    logic         btn_dn_n = 1'b1;
    logic         load = 1'b0;
    logic [N-1:0] load_val = '0;
    logic [N-1:0] num_w, num_s, num_l;
    logic         wrap_w, wrap_s, wrap_l;

    always #5 clk = ~clk;

    btn_counter #(.N(N), .MAX(63), .DEB_CYCLES(DEB), .WRAP(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n),
        .load(load), .load_val(load_val), .number(num_w), .wrap_pulse(wrap_w));
    btn_counter #(.N(N), .MAX(63), .DEB_CYCLES(DEB), .WRAP(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n),
        .load(load), .load_val(load_val), .number(num_s), .wrap_pulse(wrap_s));
    btn_counter #(.N(N), .MAX(59), .DEB_CYCLES(DEB), .WRAP(1)) dut_l (
        .clk(clk), .rst_n(rst_n), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n),
        .load(load), .load_val(load_val), .number(num_l), .wrap_pulse(wrap_l));

    typedef enum int {OP_UP, OP_DN, OP_BOTH, OP_LOAD} op_t;
    typedef struct {
        op_t op;
        int  val;
        int  exp_w, exp_s, exp_l;
        int  wr_w, wr_s, wr_l;
    } vec_t;

    vec_t vecs[10];
    vec_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   wc_w, wc_s, wc_l;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_wraps();
        wc_w = 0; wc_s = 0; wc_l = 0;
    endtask

    // Advance n cycles, sampling at each falling edge and tallying wrap pulses.
    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            if (wrap_w) wc_w++;
            if (wrap_s) wc_s++;
            if (wrap_l) wc_l++;
        end
    endtask

    task automatic do_op(input op_t op, input int val);
        logic [31:0] v;
        v = val;
        clear_wraps();
        case (op)
            OP_UP:   begin btn_up_n = 1'b0; cycles(10); btn_up_n = 1'b1; cycles(10); end
            OP_DN:   begin btn_dn_n = 1'b0; cycles(10); btn_dn_n = 1'b1; cycles(10); end
            OP_BOTH: begin
                btn_up_n = 1'b0; btn_dn_n = 1'b0; cycles(10);
                btn_up_n = 1'b1; btn_dn_n = 1'b1; cycles(10);
            end
            default: begin
                load_val = v[N-1:0];
                load = 1'b1; cycles(5);
                load = 1'b0; cycles(4);
            end
        endcase
    endtask

    task automatic check_all(input string tag, input int ew, input int es, input int el,
                             input int ww, input int ws, input int wl);
        check({tag, "_num_wrap63"}, int'(num_w), ew);
        check({tag, "_num_sat63"},  int'(num_s), es);
        check({tag, "_num_wrap59"}, int'(num_l), el);
        check({tag, "_wraps_wrap63"}, wc_w, ww);
        check({tag, "_wraps_sat63"},  wc_s, ws);
        check({tag, "_wraps_wrap59"}, wc_l, wl);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        vecs[0] = '{OP_LOAD, 10, 10, 10, 10, 0, 0, 0};
        vecs[1] = '{OP_BOTH,  0, 10, 10, 10, 0, 0, 0};
        vecs[2] = '{OP_UP,    0, 11, 11, 11, 0, 0, 0};
        vecs[3] = '{OP_DN,    0, 10, 10, 10, 0, 0, 0};
        vecs[4] = '{OP_LOAD, 62, 62, 62, 59, 0, 0, 0};
        vecs[5] = '{OP_UP,    0, 63, 63,  0, 0, 0, 1};
        vecs[6] = '{OP_UP,    0,  0, 63,  1, 1, 0, 0};
        vecs[7] = '{OP_LOAD,  0,  0,  0,  0, 0, 0, 0};
        vecs[8] = '{OP_DN,    0, 63,  0, 59, 1, 0, 1};
        vecs[9] = '{OP_LOAD,  5,  5,  5,  5, 0, 0, 0};

        clear_wraps();
        cycles(3);
        check("reset_number", int'(num_w), 0);
        check("reset_wrap", int'(wrap_w), 0);
        rst_n = 1'b1;
        cycles(2);

        // Held press: count lands on edge DEB+3 after the first low sample.
        btn_up_n = 1'b0;
        cycles(DEB + 2);
        check("hold_before_latency", int'(num_w), 0);
        cycles(1);
        check("hold_at_latency", int'(num_w), 1);
        cycles(20 - (DEB + 3));
        btn_up_n = 1'b1;
        cycles(12);
        check_all("hold_release", 1, 1, 1, 0, 0, 0);

        // Bounce shorter than the debounce window, then a real press.
        clear_wraps();
        for (int k = 0; k < 3; k++) begin
            btn_up_n = 1'b0; cycles(2);
            btn_up_n = 1'b1; cycles(2);
        end
        btn_up_n = 1'b0; cycles(10);
        btn_up_n = 1'b1; cycles(10);
        check_all("bounce", 2, 2, 2, 0, 0, 0);

        // Load edge latency and no reload while the level stays high.
        clear_wraps();
        load_val = 6'd40;
        load = 1'b1;
        cycles(2);
        check("load_before_edge3", int'(num_w), 2);
        cycles(1);
        check_all("load_edge3", 40, 40, 40, 0, 0, 0);
        load_val = 6'd50;
        btn_up_n = 1'b0; cycles(10);
        btn_up_n = 1'b1; cycles(10);
        check_all("load_held", 41, 41, 41, 0, 0, 0);
        load = 1'b0;
        cycles(4);

        for (int i = 0; i < 10; i++) begin
            sb_q.push_back(vecs[i]);
            do_op(vecs[i].op, vecs[i].val);
            e = sb_q.pop_front();
            check_all($sformatf("vec%0d", i), e.exp_w, e.exp_s, e.exp_l, e.wr_w, e.wr_s, e.wr_l);
        end

        do_op(OP_LOAD, 0);
        for (int i = 1; i <= 64; i++) begin
            sb_q.push_back('{OP_UP, 0, i % 64, (i > 63) ? 63 : i, i % 60,
                             (i == 64) ? 1 : 0, 0, (i == 60) ? 1 : 0});
            do_op(OP_UP, 0);
            e = sb_q.pop_front();
            check_all($sformatf("press%0d", i), e.exp_w, e.exp_s, e.exp_l, e.wr_w, e.wr_s, e.wr_l);
        end

        // Asynchronous reset mid-debounce with the button held through release.
        clear_wraps();
        btn_up_n = 1'b0;
        cycles(4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_wrap63", int'(num_w), 0);
        check("async_reset_sat63",  int'(num_s), 0);
        check("async_reset_wrap59", int'(num_l), 0);
        cycles(3);
        rst_n = 1'b1;
        cycles(DEB + 2);
        check("held_thru_reset_before", int'(num_s), 0);
        cycles(1);
        check("held_thru_reset_at", int'(num_s), 1);
        cycles(20);
        btn_up_n = 1'b1;
        cycles(10);
        check_all("held_thru_reset_end", 1, 1, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
